// File: rtl/mem_bus_arbiter.sv
//-----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single KS-10 memory port (SSRAM data and the memory status
// register) between the console (CSL), Unibus adapter DMA (UBA) and the CPU.
// Each transfer runs a 4-phase handshake: IDLE -> BUSY -> ACK -> RELEASE.
// If the memory never acknowledges, the transfer is ended and reported as
// non-existent memory (NXM).
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   clken            clock enable; nothing advances while low
//   req[2:0]         requests, [0]=CSL [1]=UBA [2]=CPU
//   addr_*, data_*   per-requester address word (bit 0 MSB) and write data
//   ack[2:0]         one-hot acknowledge, same bit order as req
//   rdata            read data returned to the owner (0 after an NXM)
//   nxm              one-cycle pulse when the memory timed out
//   mem_req          request to the memory wrapper
//   mem_addr/wdata   address/write data of the current owner (0 when none)
//   mem_ack/rdata    acknowledge and read data from the memory wrapper
//   grant[1:0]       current owner, 3 = none
//
// Build option: define MEM_ARB_ROUNDROBIN_EN for rotating priority
// (CSL -> UBA -> CPU -> CSL). Without it the priority is fixed CSL > UBA > CPU.
//-----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [2:0]  req,
  input  logic [0:35] addr_csl,
  input  logic [0:35] addr_uba,
  input  logic [0:35] addr_cpu,
  input  logic [0:35] data_csl,
  input  logic [0:35] data_uba,
  input  logic [0:35] data_cpu,
  output logic [2:0]  ack,
  output logic [0:35] rdata,
  output logic        nxm,
  output logic        mem_req,
  output logic [0:35] mem_addr,
  output logic [0:35] mem_wdata,
  input  logic        mem_ack,
  input  logic [0:35] mem_rdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RELEASE} stateT;

  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [1:0]      GRANT_NONE = 2'd3;

  stateT           state, stateNext;
  logic [CNTW-1:0] cnt, cntNext;
  logic [1:0]      grantNext, winner;
  logic [2:0]      ackNext, ownerOneHot;
  logic [0:35]     rdataNext;
  logic            nxmNext, memReqNext, ownerReq;
`ifdef MEM_ARB_ROUNDROBIN_EN
  logic [1:0]      rrPtr, rrPtrNext;
`endif

  // Pick the requester to serve next. With rotation the search starts at
  // rrPtr, which always names the requester after the previous winner.
  always_comb begin
    winner = 2'd0;
`ifdef MEM_ARB_ROUNDROBIN_EN
    case (rrPtr)
      2'd1:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`else
    winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
`endif
  end

  // Decode the current owner: its ack bit, its live request line and the
  // address/data it drives onto the memory port.
  always_comb begin
    ownerOneHot = 3'b000;
    ownerReq    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (grant)
      2'd0: begin
        ownerOneHot = 3'b001;
        ownerReq    = req[0];
        mem_addr    = addr_csl;
        mem_wdata   = data_csl;
      end
      2'd1: begin
        ownerOneHot = 3'b010;
        ownerReq    = req[1];
        mem_addr    = addr_uba;
        mem_wdata   = data_uba;
      end
      2'd2: begin
        ownerOneHot = 3'b100;
        ownerReq    = req[2];
        mem_addr    = addr_cpu;
        mem_wdata   = data_cpu;
      end
      default: begin
      end
    endcase
  end

  // Next-state logic. A memory ack in the same cycle as the timeout wins,
  // so the timeout branch is only taken when mem_ack is low.
  always_comb begin
    stateNext  = state;
    grantNext  = grant;
    cntNext    = cnt;
    ackNext    = ack;
    rdataNext  = rdata;
    nxmNext    = 1'b0;
    memReqNext = mem_req;
`ifdef MEM_ARB_ROUNDROBIN_EN
    rrPtrNext  = rrPtr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          grantNext  = winner;
          memReqNext = 1'b1;
          cntNext    = '0;
          stateNext  = BUSY;
`ifdef MEM_ARB_ROUNDROBIN_EN
          rrPtrNext  = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdataNext  = mem_rdata;
          memReqNext = 1'b0;
          ackNext    = ownerOneHot;
          stateNext  = ACK;
        end else if (cnt == CNT_LAST) begin
          rdataNext  = '0;
          memReqNext = 1'b0;
          nxmNext    = 1'b1;
          ackNext    = ownerOneHot;
          stateNext  = ACK;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      ACK: begin
        ackNext   = 3'b000;
        stateNext = RELEASE;
      end
      default: begin
        // RELEASE: hold the grant until the owner drops its request, so
        // the same requester can never be granted twice without a gap.
        if (!ownerReq) begin
          grantNext = GRANT_NONE;
          stateNext = IDLE;
        end
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so mem_req drops at
  // once; nothing moves while clken is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= GRANT_NONE;
      cnt     <= '0;
      ack     <= 3'b000;
      rdata   <= '0;
      nxm     <= 1'b0;
      mem_req <= 1'b0;
`ifdef MEM_ARB_ROUNDROBIN_EN
      rrPtr   <= 2'd0;
`endif
    end else if (clken) begin
      state   <= stateNext;
      grant   <= grantNext;
      cnt     <= cntNext;
      ack     <= ackNext;
      rdata   <= rdataNext;
      nxm     <= nxmNext;
      mem_req <= memReqNext;
`ifdef MEM_ARB_ROUNDROBIN_EN
      rrPtr   <= rrPtrNext;
`endif
    end
  end

endmodule
